// File: rtl/frame_length_gate.sv
// frame_length_gate: takes one L1 frame-length token, then forwards exactly the
// byte count that token describes from the data stream. Output tlast/tkeep come
// from the token. The incoming tlast is cross-checked against the token, and a
// mismatch raises a one-cycle error pulse.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a length token; data path closed
// PASS   | forwarding beats combinationally, counting down remaining bytes
// DRAIN  | discarding input beats up to and including the input tlast
module frame_length_gate #(
    parameter int C_AXIS_TDATA_WIDTH      = 8,
    parameter int C_AXIS_TKEEP_WIDTH      = C_AXIS_TDATA_WIDTH / 8,
    parameter int FRAME_LENGTH_WIDTH      = 16,
    parameter int ENABLE_TIMESTAMP_FOOTER = 1,
    parameter int TIMESTAMP_WIDTH         = 72,
    parameter int L1_LENGTH_OFFSET        = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [FRAME_LENGTH_WIDTH-1:0] s_axis_frame_length_tdata,
    input  logic                          s_axis_frame_length_tvalid,
    output logic                          s_axis_frame_length_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          err_frame_overrun,
    output logic                          err_frame_underrun,
    output logic                          err_bad_length
);

    localparam int TS_BYTES = (ENABLE_TIMESTAMP_FOOTER != 0) ? TIMESTAMP_WIDTH / 8 : 0;
    localparam int BW       = FRAME_LENGTH_WIDTH + 2;
    localparam int RW       = FRAME_LENGTH_WIDTH + 1;

    // Net adjustment from the L1 token to the byte count on the wire.
    localparam logic signed [BW-1:0] C_ADJ  = BW'(TS_BYTES - L1_LENGTH_OFFSET);
    localparam logic        [RW-1:0] C_BEAT = RW'(C_AXIS_TKEEP_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    logic [RW-1:0]        r_remaining;
    logic                 r_err_ovr;
    logic                 r_err_und;
    logic                 r_err_bad;

    state_t               w_state_next;
    logic [RW-1:0]        w_remaining_next;
    logic                 w_ovr_next;
    logic                 w_und_next;
    logic                 w_bad_next;
    logic signed [BW-1:0] w_bytes;
    logic                 w_bytes_bad;
    logic                 w_last_beat;
    logic [C_AXIS_TKEEP_WIDTH-1:0] w_mask;
    logic                 w_tok_ready;
    logic                 w_s_ready;
    logic                 w_m_valid;
    logic                 w_m_last;

    // Two extra bits of headroom keep the subtraction from wrapping, so a
    // short token shows up as a negative or zero byte count.
    assign w_bytes     = $signed({2'b00, s_axis_frame_length_tdata}) + C_ADJ;
    assign w_bytes_bad = w_bytes[BW-1] | (w_bytes == '0);
    assign w_last_beat = (r_remaining <= C_BEAT);

    // Keep only the low min(remaining, bytes-per-beat) byte lanes.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < C_AXIS_TKEEP_WIDTH; i++) begin
            w_mask[i] = (r_remaining > RW'(i));
        end
    end

    // Next-state, counter and handshake decode.
    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_ovr_next       = 1'b0;
        w_und_next       = 1'b0;
        w_bad_next       = 1'b0;
        w_tok_ready      = 1'b0;
        w_s_ready        = 1'b0;
        w_m_valid        = 1'b0;
        w_m_last         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tok_ready = 1'b1;
                if (s_axis_frame_length_tvalid) begin
                    if (w_bytes_bad) begin
                        w_bad_next   = 1'b1;
                        w_state_next = S_DRAIN;
                    end else begin
                        w_remaining_next = w_bytes[RW-1:0];
                        w_state_next     = S_PASS;
                    end
                end
            end
            S_PASS: begin
                w_s_ready = m_axis_tready;
                w_m_valid = s_axis_tvalid;
                w_m_last  = w_last_beat | s_axis_tlast;
                if (s_axis_tvalid && m_axis_tready) begin
                    if (w_last_beat && s_axis_tlast) begin
                        w_state_next = S_IDLE;
                    end else if (s_axis_tlast) begin
                        w_und_next   = 1'b1;
                        w_state_next = S_IDLE;
                    end else if (w_last_beat) begin
                        w_ovr_next   = 1'b1;
                        w_state_next = S_DRAIN;
                    end else begin
                        w_remaining_next = r_remaining - C_BEAT;
                    end
                end
            end
            S_DRAIN: begin
                w_s_ready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Control state, byte counter and registered error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_err_ovr   <= 1'b0;
            r_err_und   <= 1'b0;
            r_err_bad   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_err_ovr   <= w_ovr_next;
            r_err_und   <= w_und_next;
            r_err_bad   <= w_bad_next;
        end
    end

    // Hold off token acceptance while reset is asserted.
    assign s_axis_frame_length_tready = w_tok_ready & ~rst;
    assign s_axis_tready              = w_s_ready;
    assign m_axis_tdata               = s_axis_tdata;
    assign m_axis_tkeep               = s_axis_tkeep & w_mask;
    assign m_axis_tvalid              = w_m_valid;
    assign m_axis_tlast               = w_m_last;
    assign err_frame_overrun          = r_err_ovr;
    assign err_frame_underrun         = r_err_und;
    assign err_bad_length             = r_err_bad;

endmodule

// File: tb/tb_frame_length_gate.sv
// Directed bench for frame_length_gate: an 8-bit instance for the framing and
// error cases, and a 64-bit instance for the tkeep masking case.
module tb_frame_length_gate;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8-bit instance
    logic [15:0] a_tok;
    logic        a_tok_valid, a_tok_ready;
    logic [7:0]  a_s_tdata, a_m_tdata;
    logic [0:0]  a_s_tkeep, a_m_tkeep;
    logic        a_s_tvalid, a_s_tready, a_s_tlast;
    logic        a_m_tvalid, a_m_tready, a_m_tlast;
    logic        a_err_ovr, a_err_und, a_err_bad;

    // 64-bit instance
    logic [15:0] b_tok;
    logic        b_tok_valid, b_tok_ready;
    logic [63:0] b_s_tdata, b_m_tdata;
    logic [7:0]  b_s_tkeep, b_m_tkeep;
    logic        b_s_tvalid, b_s_tready, b_s_tlast;
    logic        b_m_tvalid, b_m_tready, b_m_tlast;
    logic        b_err_ovr, b_err_und, b_err_bad;

    frame_length_gate #(.C_AXIS_TDATA_WIDTH(8)) u_a (
        .clk(clk), .rst(rst),
        .s_axis_frame_length_tdata(a_tok),
        .s_axis_frame_length_tvalid(a_tok_valid),
        .s_axis_frame_length_tready(a_tok_ready),
        .s_axis_tdata(a_s_tdata), .s_axis_tkeep(a_s_tkeep),
        .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready),
        .s_axis_tlast(a_s_tlast),
        .m_axis_tdata(a_m_tdata), .m_axis_tkeep(a_m_tkeep),
        .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready),
        .m_axis_tlast(a_m_tlast),
        .err_frame_overrun(a_err_ovr), .err_frame_underrun(a_err_und),
        .err_bad_length(a_err_bad)
    );

    frame_length_gate #(.C_AXIS_TDATA_WIDTH(64)) u_b (
        .clk(clk), .rst(rst),
        .s_axis_frame_length_tdata(b_tok),
        .s_axis_frame_length_tvalid(b_tok_valid),
        .s_axis_frame_length_tready(b_tok_ready),
        .s_axis_tdata(b_s_tdata), .s_axis_tkeep(b_s_tkeep),
        .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
        .s_axis_tlast(b_s_tlast),
        .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep),
        .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
        .m_axis_tlast(b_m_tlast),
        .err_frame_overrun(b_err_ovr), .err_frame_underrun(b_err_und),
        .err_bad_length(b_err_bad)
    );

    int n_vec = 0;
    int n_err = 0;
    int tmo   = 0;

    logic [7:0] qa_data[$];
    bit         qa_last[$];
    logic [7:0] qb_keep[$];
    bit         qb_last[$];
    int a_ovr = 0, a_und = 0, a_bad = 0, b_errs = 0;

    // Output beat capture and error-pulse cycle counters.
    always @(negedge clk) begin
        if (a_m_tvalid && a_m_tready) begin
            qa_data.push_back(a_m_tdata);
            qa_last.push_back(a_m_tlast);
        end
        if (b_m_tvalid && b_m_tready) begin
            qb_keep.push_back(b_m_tkeep);
            qb_last.push_back(b_m_tlast);
        end
        if (a_err_ovr) a_ovr++;
        if (a_err_und) a_und++;
        if (a_err_bad) a_bad++;
        if (b_err_ovr || b_err_und || b_err_bad) b_errs++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_token(input logic [15:0] v);
        int t = 0;
        a_tok = v;
        a_tok_valid = 1'b1;
        @(negedge clk);
        while (!a_tok_ready) begin
            t++;
            if (t > 200) begin tmo++; break; end
            @(negedge clk);
        end
        @(posedge clk); #1;
        a_tok_valid = 1'b0;
    endtask

    task automatic a_beat(input logic [7:0] d, input logic l, input bit bp);
        int t = 0;
        a_s_tdata  = d;
        a_s_tkeep  = 1'b1;
        a_s_tlast  = l;
        a_s_tvalid = 1'b1;
        if (bp) a_m_tready = 1'($urandom_range(0, 1));
        @(negedge clk);
        while (!a_s_tready) begin
            t++;
            if (t > 200) begin tmo++; break; end
            @(posedge clk); #1;
            if (bp) a_m_tready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        @(posedge clk); #1;
        a_s_tvalid = 1'b0;
        a_s_tlast  = 1'b0;
    endtask

    // Beat i (1-based) carries byte seed+i; tlast on beat last_at (0 = never).
    task automatic a_frame(input int n, input int last_at, input int seed, input bit bp);
        for (int i = 1; i <= n; i++) begin
            a_beat(8'(seed + i), (i == last_at), bp);
        end
    endtask

    task automatic b_token(input logic [15:0] v);
        int t = 0;
        b_tok = v;
        b_tok_valid = 1'b1;
        @(negedge clk);
        while (!b_tok_ready) begin
            t++;
            if (t > 200) begin tmo++; break; end
            @(negedge clk);
        end
        @(posedge clk); #1;
        b_tok_valid = 1'b0;
    endtask

    task automatic b_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int t = 0;
        b_s_tdata  = d;
        b_s_tkeep  = k;
        b_s_tlast  = l;
        b_s_tvalid = 1'b1;
        @(negedge clk);
        while (!b_s_tready) begin
            t++;
            if (t > 200) begin tmo++; break; end
            @(negedge clk);
        end
        @(posedge clk); #1;
        b_s_tvalid = 1'b0;
        b_s_tlast  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Output frame since index i0: beat count, bytes, single tlast on last beat.
    task automatic check_frame(input string tag, input int i0, input int nexp, input int seed);
        int bad = 0;
        int nl  = 0;
        int sz  = qa_data.size();
        chk({tag, "_beats"}, 64'(sz - i0), 64'(nexp));
        for (int k = 0; k < nexp && (i0 + k) < sz; k++) begin
            if (qa_data[i0 + k] !== 8'(seed + k + 1)) bad++;
            if (qa_last[i0 + k]) nl++;
        end
        chk({tag, "_data_bad"}, 64'(bad), 64'd0);
        chk({tag, "_tlast_count"}, 64'(nl), 64'd1);
        chk({tag, "_tlast_pos"}, (sz >= i0 + nexp && nexp > 0) ? 64'(qa_last[i0 + nexp - 1]) : 64'd0, 64'd1);
    endtask

    initial begin
        int i0, o0, u0, b0;
        a_tok = '0; a_tok_valid = 1'b0;
        a_s_tdata = '0; a_s_tkeep = '0; a_s_tvalid = 1'b0; a_s_tlast = 1'b0;
        a_m_tready = 1'b1;
        b_tok = '0; b_tok_valid = 1'b0;
        b_s_tdata = '0; b_s_tkeep = '0; b_s_tvalid = 1'b0; b_s_tlast = 1'b0;
        b_m_tready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_tok_ready", 64'(a_tok_ready), 64'd1);
        chk("rst_s_tready", 64'(a_s_tready), 64'd0);
        chk("rst_m_tvalid", 64'(a_m_tvalid), 64'd0);
        chk("rst_errs", 64'({a_err_ovr, a_err_und, a_err_bad}), 64'd0);
        @(posedge clk); #1;

        // Token 84 -> 69 bytes, input tlast on beat 69
        i0 = qa_data.size(); o0 = a_ovr; u0 = a_und; b0 = a_bad;
        a_token(16'd84);
        a_frame(69, 69, 0, 1'b0);
        idle_cycles(3);
        check_frame("exact", i0, 69, 0);
        chk("exact_errs", 64'((a_ovr - o0) + (a_und - u0) + (a_bad - b0)), 64'd0);
        chk("exact_idle", 64'(a_tok_ready), 64'd1);

        // 71 input beats against a 69-byte token
        i0 = qa_data.size(); o0 = a_ovr;
        a_token(16'd84);
        a_frame(71, 71, 16, 1'b0);
        idle_cycles(3);
        check_frame("overrun", i0, 69, 16);
        chk("overrun_pulse", 64'(a_ovr - o0), 64'd1);
        chk("overrun_tok_ready", 64'(a_tok_ready), 64'd1);

        // 67 input beats against a 69-byte token
        i0 = qa_data.size(); u0 = a_und; o0 = a_ovr;
        a_token(16'd84);
        a_frame(67, 67, 32, 1'b0);
        idle_cycles(3);
        check_frame("underrun", i0, 67, 32);
        chk("underrun_pulse", 64'(a_und - u0), 64'd1);
        chk("underrun_no_ovr", 64'(a_ovr - o0), 64'd0);

        // Token 15 -> 0 bytes: whole frame drained
        i0 = qa_data.size(); b0 = a_bad;
        a_token(16'd15);
        a_frame(20, 20, 48, 1'b0);
        idle_cycles(3);
        chk("badlen_pulse", 64'(a_bad - b0), 64'd1);
        chk("badlen_beats_out", 64'(qa_data.size() - i0), 64'd0);
        i0 = qa_data.size(); o0 = a_ovr; u0 = a_und;
        a_token(16'd84);
        a_frame(69, 69, 64, 1'b0);
        idle_cycles(3);
        check_frame("after_bad", i0, 69, 64);
        chk("after_bad_errs", 64'((a_ovr - o0) + (a_und - u0)), 64'd0);

        // 64-bit lanes: 69 bytes -> 8 full beats + 5-byte tail
        b_token(16'd84);
        for (int i = 1; i <= 9; i++) begin
            b_beat({8{8'(i)}}, 8'hFF, (i == 9));
        end
        idle_cycles(3);
        chk("w64_beats", 64'(qb_keep.size()), 64'd9);
        if (qb_keep.size() == 9) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("w64_keep%0d", i + 1), 64'(qb_keep[i]), 64'hFF);
                chk($sformatf("w64_last%0d", i + 1), 64'(qb_last[i]), 64'd0);
            end
            chk("w64_keep9", 64'(qb_keep[8]), 64'h1F);
            chk("w64_last9", 64'(qb_last[8]), 64'd1);
        end
        chk("w64_errs", 64'(b_errs), 64'd0);

        // Random output backpressure on a 69-byte frame
        i0 = qa_data.size(); o0 = a_ovr; u0 = a_und;
        a_token(16'd84);
        a_frame(69, 69, 80, 1'b1);
        a_m_tready = 1'b1;
        idle_cycles(3);
        check_frame("bp", i0, 69, 80);
        chk("bp_errs", 64'((a_ovr - o0) + (a_und - u0)), 64'd0);

        // Reset while beat 30 of the next frame is presented
        o0 = a_ovr; u0 = a_und; b0 = a_bad;
        a_token(16'd84);
        a_frame(29, 0, 96, 1'b0);
        a_s_tdata = 8'(96 + 30); a_s_tkeep = 1'b1; a_s_tlast = 1'b0; a_s_tvalid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        a_s_tvalid = 1'b0;
        @(negedge clk);
        chk("mid_rst_m_tvalid", 64'(a_m_tvalid), 64'd0);
        chk("mid_rst_s_tready", 64'(a_s_tready), 64'd0);
        chk("mid_rst_tok_ready", 64'(a_tok_ready), 64'd1);
        @(posedge clk); #1;
        i0 = qa_data.size();
        a_token(16'd84);
        a_frame(69, 69, 112, 1'b0);
        idle_cycles(3);
        check_frame("post_rst", i0, 69, 112);
        chk("post_rst_errs", 64'((a_ovr - o0) + (a_und - u0) + (a_bad - b0)), 64'd0);

        chk("timeouts", 64'(tmo), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
